servo_sequencer: RTL and testbench
==================================

SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clocks per one-second dwell tick.
REQ-002 SHALL have parameter NUM_STEPS, default 8, step-table depth; power of two, 2..16.
REQ-003 SHALL have parameter WIDTH_W, default 18, pulse-width field width in clocks.
REQ-004 SHALL have parameter SEC_W, default 4, dwell field width in seconds.
REQ-005 SHALL have parameter PERIOD, default 2000000, PWM frame length in clocks.
REQ-006 SHALL have parameter HOME_WIDTH, default 145000, idle/home pulse width (90 deg).
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port reset_servo_seq, input, 1, synchronous active-high reset.
REQ-009 SHALL have port enable_seq, input, 1, level run request.
REQ-010 SHALL have port stop, input, 1, pause; freezes dwell timer and step index.
REQ-011 SHALL have port loop_mode, input, 1, 1 = restart at step 0 after last step, 0 = one-shot.
REQ-012 SHALL have port seq_len, input, log2(NUM_STEPS)+1, number of active steps; sampled on start.
REQ-013 SHALL have port wr_en, input, 1, step-table write strobe.
REQ-014 SHALL have port wr_addr, input, log2(NUM_STEPS), table entry index.
REQ-015 SHALL have port wr_width, input, WIDTH_W, pulse width for the entry.
REQ-016 SHALL have port wr_secs, input, SEC_W, dwell seconds for the entry.
REQ-017 SHALL have port width_out, output, WIDTH_W, current commanded pulse width (registered).
REQ-018 SHALL have port pwm_out, output, 1, servo PWM: high while frame counter < width_out.
REQ-019 SHALL have port step_idx, output, log2(NUM_STEPS), index of executing step.
REQ-020 SHALL have port busy, output, 1, high in RUN.
REQ-021 SHALL have port done_seq, output, 1, high in DONE.

Function
REQ-022 SHALL hold a NUM_STEPS-entry table of {width, secs}, written in one clock when wr_en=1, in any state.
REQ-023 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-024 IDLE: width_out=HOME_WIDTH; on enable_seq=1 and seq_len!=0 latch seq_len (values >NUM_STEPS clamp to NUM_STEPS), step_idx=0, go LOAD.
REQ-025 IDLE with enable_seq=1 and seq_len=0 SHALL go directly to DONE.
REQ-026 LOAD (one clock): latch entry[step_idx] into width_out and dwell counter, clear tick prescaler, go RUN.
REQ-027 RUN: prescaler counts 0..CLK_HZ-1; at wrap dwell counter decrements; when dwell counter is 0 at a wrap, or is 0 on entry (secs=0), step ends.
REQ-028 Step end: if step_idx < latched_len-1, increment step_idx and go LOAD; else if loop_mode=1, step_idx=0 and go LOAD; else go DONE.
REQ-029 Step latency SHALL be exactly secs*CLK_HZ+1 clocks from LOAD to next LOAD for secs>=1, and 2 clocks for secs=0.
REQ-030 stop=1 in RUN SHALL freeze prescaler, dwell counter, and step_idx; width_out and pwm_out continue unchanged.
REQ-031 enable_seq=0 in LOAD or RUN SHALL abort to IDLE next clock; width_out returns to HOME_WIDTH.
REQ-032 DONE: width_out holds last step width; done_seq=1; remains until enable_seq=0, then IDLE.
REQ-033 A table write to the executing entry SHALL NOT alter the current dwell or width_out; it takes effect on the next LOAD of that entry.
REQ-034 Frame counter SHALL run 0..PERIOD-1 continuously, independent of state; width_out changes take effect at the next frame start (shadow register).
REQ-035 width_out >= PERIOD SHALL yield pwm_out constantly high; width 0 SHALL yield constantly low.

Reset
REQ-036 reset_servo_seq=1 SHALL force IDLE, width_out=HOME_WIDTH, shadow=HOME_WIDTH, step_idx=0, busy=0, done_seq=0, counters=0, pwm_out=0.
REQ-037 Reset SHALL load every table entry to {HOME_WIDTH, 0}.
REQ-038 Reset SHALL take priority over enable_seq, stop, and wr_en in the same clock, including mid-RUN.

Verification (CLK_HZ=10, PERIOD=100, NUM_STEPS=4, HOME_WIDTH=50)
REQ-039 Table {60,2},{30,1},{50,0}, seq_len=3, loop_mode=0, enable held -> width_out 60 for 21 clks, 30 for 11, 50 for 2, then done_seq=1 with width_out=50.
REQ-040 Same table, loop_mode=1 -> after step 2, step_idx returns to 0 and width_out=60; done_seq never asserts.
REQ-041 stop=1 for 15 clks during step 0 -> step 0 lasts 36 clks; width_out stays 60 throughout.
REQ-042 enable_seq dropped mid-step 1 -> next clk busy=0, width_out=50, step_idx=0; reasserting restarts at step 0.
REQ-043 Reset asserted mid-RUN with wr_en=1 -> all outputs at reset values; table reads back {50,0}; the write is discarded.
REQ-044 width_out=30 -> pwm_out high 30 of every 100 clks, aligned to frame start; width 120 -> constant high.

Source files
------------

// File: rtl/servo_sequencer.sv
// Servo step sequencer: plays a table of {pulse width, dwell seconds} steps into a
// PWM servo output, with loop/one-shot modes, pause, and abort back to home.
module servo_sequencer #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned WIDTH_W    = 18,
  parameter int unsigned SEC_W      = 4,
  parameter int unsigned PERIOD     = 2000000,
  parameter int unsigned HOME_WIDTH = 145000,
  localparam int unsigned IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               reset_servo_seq,
  input  logic               enable_seq,
  input  logic               stop,
  input  logic               loop_mode,
  input  logic [IDX_W:0]     seq_len,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [WIDTH_W-1:0] wr_width,
  input  logic [SEC_W-1:0]   wr_secs,
  output logic [WIDTH_W-1:0] width_out,
  output logic               pwm_out,
  output logic [IDX_W-1:0]   step_idx,
  output logic               busy,
  output logic               done_seq
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [WIDTH_W-1:0] HOME       = WIDTH_W'(HOME_WIDTH);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W:0]     MAX_LEN    = (IDX_W + 1)'(NUM_STEPS);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     len_q, len_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [SEC_W-1:0]   dwell_q, dwell_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic [WIDTH_W-1:0] shadow_q, shadow_d;
  logic               pwm_q, pwm_d;
  logic               step_end, step_last;

  logic [WIDTH_W-1:0] tbl_width [NUM_STEPS];
  logic [SEC_W-1:0]   tbl_secs  [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (reset_servo_seq) begin
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        tbl_width[i] <= HOME;
        tbl_secs[i]  <= '0;
      end
    end else if (wr_en) begin
      tbl_width[wr_addr] <= wr_width;
      tbl_secs[wr_addr]  <= wr_secs;
    end
  end

  assign step_last = ({1'b0, idx_q} + (IDX_W + 1)'(1)) >= len_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    width_d  = width_q;
    dwell_d  = dwell_q;
    presc_d  = presc_q;
    step_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        width_d = HOME;
        idx_d   = '0;
        if (enable_seq) begin
          if (seq_len == '0) begin
            state_d = StDone;
          end else begin
            len_d   = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        width_d = tbl_width[idx_q];
        dwell_d = tbl_secs[idx_q];
        presc_d = '0;
        state_d = StRun;
      end
      StRun: begin
        // Decrement on each prescaler wrap; the step ends on the wrap that empties
        // the dwell, giving secs*CLK_HZ RUN clocks (one clock for secs=0).
        if (!stop) begin
          if (dwell_q == '0) begin
            step_end = 1'b1;
          end else if (presc_q == PRE_LAST) begin
            presc_d  = '0;
            dwell_d  = dwell_q - SEC_W'(1);
            step_end = (dwell_q == SEC_W'(1));
          end else begin
            presc_d = presc_q + PRE_W'(1);
          end
        end
      end
      StDone: begin
        if (!enable_seq) begin
          state_d = StIdle;
          width_d = HOME;
        end
      end
      default: state_d = StIdle;
    endcase

    if (step_end) begin
      state_d = StLoad;
      if (!step_last) begin
        idx_d = idx_q + IDX_W'(1);
      end else if (loop_mode) begin
        idx_d = '0;
      end else begin
        state_d = StDone;
      end
    end

    // Dropping the run request overrides everything else while active.
    if ((state_q == StLoad || state_q == StRun) && !enable_seq) begin
      state_d = StIdle;
      width_d = HOME;
      idx_d   = '0;
    end
  end

  // Frame counter runs free; the shadow picks up width_out only at frame start.
  always_comb begin
    if (frame_q == FRAME_LAST) begin
      frame_d  = '0;
      shadow_d = width_q;
    end else begin
      frame_d  = frame_q + CNT_W'(1);
      shadow_d = shadow_q;
    end
    pwm_d = 32'(frame_d) < 32'(shadow_d);
  end

  always_ff @(posedge clk) begin
    if (reset_servo_seq) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      len_q    <= '0;
      width_q  <= HOME;
      dwell_q  <= '0;
      presc_q  <= '0;
      frame_q  <= '0;
      shadow_q <= HOME;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      width_q  <= width_d;
      dwell_q  <= dwell_d;
      presc_q  <= presc_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign width_out = width_q;
  assign pwm_out   = pwm_q;
  assign step_idx  = idx_q;
  assign busy      = (state_q == StRun);
  assign done_seq  = (state_q == StDone);

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed self-checking bench for servo_sequencer with small timing parameters.
module tb_servo_sequencer;

  localparam int unsigned CLK_HZ     = 10;
  localparam int unsigned NUM_STEPS  = 4;
  localparam int unsigned WIDTH_W    = 18;
  localparam int unsigned SEC_W      = 4;
  localparam int unsigned PERIOD     = 100;
  localparam int unsigned HOME_WIDTH = 50;
  localparam int unsigned IDX_W      = 2;

  logic               clk = 1'b0;
  logic               reset_servo_seq = 1'b1;
  logic               enable_seq = 1'b0;
  logic               stop = 1'b0;
  logic               loop_mode = 1'b0;
  logic [IDX_W:0]     seq_len = '0;
  logic               wr_en = 1'b0;
  logic [IDX_W-1:0]   wr_addr = '0;
  logic [WIDTH_W-1:0] wr_width = '0;
  logic [SEC_W-1:0]   wr_secs = '0;
  logic [WIDTH_W-1:0] width_out;
  logic               pwm_out;
  logic [IDX_W-1:0]   step_idx;
  logic               busy;
  logic               done_seq;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int c_r      = 0;

  servo_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .NUM_STEPS (NUM_STEPS),
    .WIDTH_W   (WIDTH_W),
    .SEC_W     (SEC_W),
    .PERIOD    (PERIOD),
    .HOME_WIDTH(HOME_WIDTH)
  ) dut (
    .clk            (clk),
    .reset_servo_seq(reset_servo_seq),
    .enable_seq     (enable_seq),
    .stop           (stop),
    .loop_mode      (loop_mode),
    .seq_len        (seq_len),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_width       (wr_width),
    .wr_secs        (wr_secs),
    .width_out      (width_out),
    .pwm_out        (pwm_out),
    .step_idx       (step_idx),
    .busy           (busy),
    .done_seq       (done_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input int a, input int w, input int s);
    wr_en    = 1'b1;
    wr_addr  = IDX_W'(a);
    wr_width = WIDTH_W'(w);
    wr_secs  = SEC_W'(s);
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic count_idx(input int idx, output int n);
    n = 0;
    while (int'(step_idx) == idx && !done_seq && n < 200) begin
      n++;
      tick();
    end
  endtask

  function automatic int frame_pos();
    return (cyc - c_r) % int'(PERIOD);
  endfunction

  task automatic wait_frame(input int f);
    int k;
    k = 0;
    while (frame_pos() != f && k < 200) begin
      tick();
      k++;
    end
  endtask

  task automatic pwm_profile(input int w, output int high, output int errs);
    high = 0;
    errs = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      if (pwm_out != (i < w)) errs++;
      if (pwm_out) high++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, ok_w, high, errs;

    tick();
    tick();
    check("rst_width", int'(width_out), 50);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_idx", int'(step_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_seq), 0);
    reset_servo_seq = 1'b0;

    wr(0, 60, 2);
    wr(1, 30, 1);
    wr(2, 50, 0);

    // One-shot run of three steps
    seq_len    = 3'd3;
    loop_mode  = 1'b0;
    enable_seq = 1'b1;
    tick();
    check("load_busy", int'(busy), 0);
    count_idx(0, n);
    check("os_step0_len", n, 21);
    check("os_width0", int'(width_out), 60);
    count_idx(1, n);
    check("os_step1_len", n, 11);
    check("os_width1", int'(width_out), 30);
    count_idx(2, n);
    check("os_step2_len", n, 2);
    check("os_done", int'(done_seq), 1);
    check("os_done_width", int'(width_out), 50);
    check("os_done_idx", int'(step_idx), 2);
    tick();
    check("done_holds", int'(done_seq), 1);
    enable_seq = 1'b0;
    tick();
    check("done_release", int'(done_seq), 0);

    // Loop mode
    loop_mode  = 1'b1;
    enable_seq = 1'b1;
    tick();
    count_idx(0, n);
    check("lp_step0_len", n, 21);
    count_idx(1, n);
    check("lp_step1_len", n, 11);
    count_idx(2, n);
    check("lp_step2_len", n, 2);
    check("lp_wrap_idx", int'(step_idx), 0);
    check("lp_no_done", int'(done_seq), 0);
    tick();
    check("lp_wrap_width", int'(width_out), 60);
    count_idx(0, n);
    check("lp_step0_again", n, 20);

    // Abort mid step 1, then restart
    tick();
    tick();
    tick();
    check("ab_in_step1", int'(step_idx), 1);
    enable_seq = 1'b0;
    tick();
    check("ab_busy", int'(busy), 0);
    check("ab_width", int'(width_out), 50);
    check("ab_idx", int'(step_idx), 0);
    loop_mode  = 1'b0;
    enable_seq = 1'b1;
    tick();
    tick();
    check("rs_width", int'(width_out), 60);
    check("rs_idx", int'(step_idx), 0);
    check("rs_busy", int'(busy), 1);
    enable_seq = 1'b0;
    tick();

    // Pause during step 0, plus a write to the executing entry
    seq_len    = 3'd3;
    enable_seq = 1'b1;
    wr_addr    = '0;
    wr_width   = 18'd70;
    wr_secs    = 4'd2;
    tick();
    n    = 0;
    ok_w = 1;
    while (int'(step_idx) == 0 && n < 200) begin
      n++;
      if (n >= 2 && int'(width_out) != 60) ok_w = 0;
      stop  = (n >= 5 && n < 20);
      wr_en = (n == 3);
      tick();
    end
    stop  = 1'b0;
    wr_en = 1'b0;
    check("stop_step0_len", n, 36);
    check("stop_width", ok_w, 1);
    check("stop_next_idx", int'(step_idx), 1);
    enable_seq = 1'b0;
    tick();

    // Zero-length sequence goes straight to DONE
    seq_len    = 3'd0;
    enable_seq = 1'b1;
    tick();
    check("zlen_done", int'(done_seq), 1);
    check("zlen_width", int'(width_out), 50);
    check("zlen_busy", int'(busy), 0);
    enable_seq = 1'b0;
    tick();

    // Rewritten entry 0 takes effect on its next load
    seq_len    = 3'd3;
    enable_seq = 1'b1;
    tick();
    tick();
    check("new_entry_width", int'(width_out), 70);
    tick();

    // Reset mid-RUN beats a same-clock write; seq_len=7 clamps to 4
    reset_servo_seq = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = '0;
    wr_width = 18'd99;
    wr_secs  = 4'd3;
    stop     = 1'b1;
    seq_len  = 3'd7;
    tick();
    check("mr_width", int'(width_out), 50);
    check("mr_busy", int'(busy), 0);
    check("mr_done", int'(done_seq), 0);
    check("mr_idx", int'(step_idx), 0);
    check("mr_pwm", int'(pwm_out), 0);
    reset_servo_seq = 1'b0;
    wr_en = 1'b0;
    stop  = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      count_idx(s, n);
      check($sformatf("tbl_step%0d_len", s), n, 2);
    end
    check("clamp_done", int'(done_seq), 1);
    check("clamp_width", int'(width_out), 50);
    check("clamp_idx", int'(step_idx), 3);

    // PWM framing, referenced to a fresh reset
    enable_seq      = 1'b0;
    reset_servo_seq = 1'b1;
    tick();
    c_r             = cyc;
    reset_servo_seq = 1'b0;
    wr(0, 30, 0);
    seq_len = 3'd1;
    wait_frame(33);
    enable_seq = 1'b1;
    tick();
    tick();
    tick();
    check("pw30_done", int'(done_seq), 1);
    check("pw30_width", int'(width_out), 30);
    wait_frame(45);
    check("shadow_hold_hi", int'(pwm_out), 1);
    wait_frame(50);
    check("shadow_hold_lo", int'(pwm_out), 0);
    wait_frame(0);
    pwm_profile(30, high, errs);
    check("pw30_high", high, 30);
    check("pw30_align", errs, 0);

    enable_seq = 1'b0;
    tick();
    wr(0, 120, 0);
    enable_seq = 1'b1;
    tick();
    tick();
    tick();
    check("pw120_width", int'(width_out), 120);
    wait_frame(0);
    pwm_profile(120, high, errs);
    check("pw120_high", high, 100);

    enable_seq = 1'b0;
    tick();
    wr(0, 0, 0);
    enable_seq = 1'b1;
    tick();
    tick();
    tick();
    wait_frame(0);
    pwm_profile(0, high, errs);
    check("pw0_high", high, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
